// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and start-glitch rejection.
// Emits a one-clk rx_done per good frame and a one-clk frame_err when the stop bit is low.
module uart_rx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600,
    localparam int DIV   = CLK_HZ / (BAUD * 16),
    localparam int TW    = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_meta_d;
    logic            rx_s_q, rx_s_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic            tick;
    logic [3:0]      s_cnt_q, s_cnt_d;
    logic [2:0]      b_cnt_q, b_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_done_q, rx_done_d;
    logic            frame_err_q, frame_err_d;

    // Synchronizer and free-running oversample tick generator
    always_comb begin
        rx_meta_d  = rx;
        rx_s_d     = rx_meta_q;
        tick       = (tick_cnt_q == TW'(DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath counters; everything advances only on tick
    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        b_cnt_d = b_cnt_q;
        shift_d = shift_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d = START;
                        s_cnt_d = 4'd0;
                    end
                end
                START: begin
                    if (s_cnt_q == 4'd7) begin
                        s_cnt_d = 4'd0;
                        b_cnt_d = 3'd0;
                        state_d = rx_s_q ? IDLE : DATA;
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
                DATA: begin
                    if (s_cnt_q == 4'd15) begin
                        shift_d = {rx_s_q, shift_q[7:1]};
                        s_cnt_d = 4'd0;
                        if (b_cnt_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            b_cnt_d = b_cnt_q + 3'd1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
                STOP: begin
                    if (s_cnt_q == 4'd15) begin
                        s_cnt_d = 4'd0;
                        state_d = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs: pulses are decided on the stop-bit sample tick only
    always_comb begin
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        rx_data_d   = rx_data_q;
        if (tick && state_q == STOP && s_cnt_q == 4'd15) begin
            if (rx_s_q) begin
                rx_done_d = 1'b1;
                rx_data_d = shift_q;
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            tick_cnt_q  <= '0;
            s_cnt_q     <= 4'd0;
            b_cnt_q     <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            tick_cnt_q  <= tick_cnt_d;
            s_cnt_q     <= s_cnt_d;
            b_cnt_q     <= b_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx at DIV=10 (160 clks per bit).
// A monitor records every pulse; the main sequence compares against a queue-based frame model.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] got_q[$];
    int ferr_cnt = 0;
    int both_cnt = 0;

    uart_rx #(.CLK_HZ(1_600_000), .BAUD(10_000)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data),
        .rx_done(rx_done), .frame_err(frame_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_done) got_q.push_back(rx_data);
            if (frame_err) ferr_cnt++;
            if (rx_done && frame_err) both_cnt++;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives the first nbits of a 10-bit frame; reports whether busy was high mid-bit for start..bit7
    task automatic send(input logic [7:0] b, input logic stop_bit, input int bclk,
                        input int nbits, output logic busy_all);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        busy_all = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            rx = fr[i];
            wait_clks(bclk / 2);
            if (i < 9) busy_all &= rx_busy;
            wait_clks(bclk - bclk / 2);
        end
        rx = 1'b1;
    endtask

    task automatic check_next(input string tag, input logic [7:0] exp);
        int have;
        have = (got_q.size() > 0) ? 1 : 0;
        check({tag, "_present"}, have, 1);
        if (have != 0) check(tag, got_q.pop_front(), exp);
    endtask

    initial begin
        logic       busy;
        logic [7:0] last_good;
        logic [7:0] b2b [4];
        int         ferr_exp;
        logic [7:0] rb;
        logic       bad;
        logic       prev_bad;
        int         bclk;
        int         gap;

        b2b = '{8'h43, 8'h53, 8'h4D, 8'h48};
        rst = 1'b1;
        rx  = 1'b1;
        wait_clks(5);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_done", rx_done, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_rx_busy", rx_busy, 1'b0);
        rst = 1'b0;
        wait_clks(37);

        // Single good frame
        send(8'h32, 1'b1, 160, 10, busy);
        check("busy_0x32", busy, 1'b1);
        wait_clks(20);
        check_next("byte_0x32", 8'h32);
        check("data_0x32", rx_data, 8'h32);
        check("ferr_0x32", ferr_cnt, 0);
        check("extra_0x32", got_q.size(), 0);

        // Back-to-back frames with no idle gap
        foreach (b2b[i]) send(b2b[i], 1'b1, 160, 10, busy);
        wait_clks(20);
        check("b2b_count", got_q.size(), 4);
        foreach (b2b[i]) check_next($sformatf("b2b_%0d", i), b2b[i]);
        last_good = 8'h48;

        // Stop bit low: frame error, data held
        send(8'h55, 1'b0, 160, 10, busy);
        wait_clks(250);
        check("ferr_0x55", ferr_cnt, 1);
        check("nodone_0x55", got_q.size(), 0);
        check("hold_0x55", rx_data, last_good);
        ferr_exp = 1;

        // Short glitch on an idle line is rejected
        rx = 1'b0;
        wait_clks(20);
        check("glitch_busy_hi", rx_busy, 1'b1);
        wait_clks(20);
        rx = 1'b1;
        wait_clks(100);
        check("glitch_busy_lo", rx_busy, 1'b0);
        check("glitch_nodone", got_q.size(), 0);
        check("glitch_noferr", ferr_cnt, ferr_exp);

        // Reset during bit 4 of 0xA5 aborts silently
        send(8'hA5, 1'b1, 160, 5, busy);
        rx = 1'b0;
        wait_clks(80);
        rst = 1'b1;
        wait_clks(3);
        check("abort_busy", rx_busy, 1'b0);
        check("abort_data", rx_data, 8'h00);
        rx = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        wait_clks(300);
        check("abort_nodone", got_q.size(), 0);
        check("abort_noferr", ferr_cnt, ferr_exp);
        send(8'h3C, 1'b1, 160, 10, busy);
        wait_clks(20);
        check_next("after_abort", 8'h3C);
        check("after_abort_data", rx_data, 8'h3C);

        // Baud tolerance +/-2%
        for (int k = 0; k < 2; k++) begin
            bclk = (k == 0) ? 157 : 163;
            send(8'h00, 1'b1, bclk, 10, busy);
            send(8'hFF, 1'b1, bclk, 10, busy);
            wait_clks(20);
            check($sformatf("skew%0d_count", bclk), got_q.size(), 2);
            check_next($sformatf("skew%0d_00", bclk), 8'h00);
            check_next($sformatf("skew%0d_ff", bclk), 8'hFF);
        end
        last_good = 8'hFF;

        // Random frames: model keeps last good byte and the expected error count
        prev_bad = 1'b0;
        for (int n = 0; n < 10; n++) begin
            rb   = 8'($urandom_range(0, 255));
            bad  = ($urandom_range(0, 3) == 0);
            bclk = bad ? 160 : $urandom_range(157, 163);
            gap  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 300);
            if (prev_bad && gap < 200) gap = 200;
            wait_clks(gap);
            send(rb, !bad, bclk, 10, busy);
            check($sformatf("rnd%0d_busy", n), busy, 1'b1);
            if (bad) begin
                ferr_exp++;
                check($sformatf("rnd%0d_nodone", n), got_q.size(), 0);
            end else begin
                last_good = rb;
                check_next($sformatf("rnd%0d", n), rb);
            end
            check($sformatf("rnd%0d_ferr", n), ferr_cnt, ferr_exp);
            check($sformatf("rnd%0d_data", n), rx_data, last_good);
            prev_bad = bad;
        end

        wait_clks(300);
        check("never_both", both_cnt, 0);
        check("final_idle", rx_busy, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
